dpd_capture: RTL and testbench
==============================

Name: dpd_capture

Overview:
- Feedback-path capture buffer for DPD training; the receive-side counterpart of the training-signal player.
- A rising edge on start triggers capture of exactly 1024 consecutive I/Q feedback samples (PA output via observation ADC/DDC) into a dual-port RAM.
- Capture begins after a programmable alignment delay that compensates loop latency.
- The coefficient estimator then reads the captured frame back through a simple random-access read port.

Parameters:
- W, 16, sample width of fb_i/fb_q and rd_i/rd_q (two's complement, stored verbatim).
- AW, 10, buffer address width; depth = 2**AW = 1024.
- DW, 8, width of the alignment-delay input.

Ports:
- clk  input  1  single clock; all logic is clocked on its rising edge.
- reset_b  input  1  asynchronous active-low reset.
- start  input  1  capture request; a level signal, internally edge-detected.
- delay  input  DW  alignment delay in clk cycles; sampled on the start edge.
- fb_i  input  W  feedback I sample, one per clk.
- fb_q  input  W  feedback Q sample, one per clk.
- busy  output  1  high in WAIT or CAPT.
- done  output  1  high in DONE; buffer holds a complete frame.
- rd_en  input  1  read request.
- rd_addr  input  AW  read address.
- rd_i  output  W  read data I.
- rd_q  output  W  read data Q.
- rd_valid  output  1  rd_i/rd_q valid; asserted one cycle after rd_en.

Behaviour:
- Start detect:
  - start passes through two flops (s0, s1). Pulse sp <= s0 & ~s1, so sp is registered.
  - These three flops are not reset; this matches the training-signal player so both ends share an identical front-end latency.
- FSM states IDLE, WAIT, CAPT, DONE.
  - Reset state is IDLE, with busy=0, done=0, rd_valid=0, rd_i=0, rd_q=0.
  - Any state, sp=1: latch dly_cnt <= delay, wr_addr <= 0, done <= 0, go to WAIT. A start edge during WAIT/CAPT/DONE aborts and restarts; partial data is overwritten.
  - WAIT: if dly_cnt==0 go to CAPT, else decrement dly_cnt.
  - CAPT: each cycle write {fb_i, fb_q} to RAM[wr_addr] and increment wr_addr. After the write at wr_addr==2**AW-1, go to DONE; no wrap and no extra write.
  - DONE: done=1, held until the next sp or reset.
- Alignment: the sample written to address 0 is the fb_i/fb_q present on the clk edge 2+delay cycles after the edge where sp is first high.
  - With delay=0 this matches the player's output timing, so a zero-latency loopback captures sample k at address k.
- Capture length is exactly 2**AW samples. busy is high for delay+1 WAIT cycles plus 2**AW CAPT cycles.
- Read port:
  - rd_en=1 registers RAM[rd_addr] into rd_i/rd_q and sets rd_valid=1 on the next cycle.
  - rd_en=0 gives rd_valid=0 next cycle, and rd_i/rd_q hold their last value.
  - Reads are allowed in any state.
  - Same-cycle read and write to the same address returns the OLD contents (read-before-write).
- RAM contents are not reset or initialised; they are undefined until the first complete capture.
- Reset mid-capture: immediately IDLE, outputs cleared, RAM keeps partial data, done stays 0.
- delay changes after the start edge have no effect on the current capture.

Decomposition:
- Shared package dpd_pkg: typedefs u1, u10 (already in use), plus the state enum cap_state_t {IDLE, WAIT, CAPT, DONE} and constant DPD_FRAME_LEN = 1024.
- One sub-module, dpd_iq_ram: simple dual-port RAM, 2*W wide, 2**AW deep.
  - Registered read, read-before-write, no reset on the array.
  - Infers block RAM.
- The FSM, start detect and delay counter stay in dpd_capture.

Test Plan:
- Loopback, delay=0: fb_i/fb_q driven by a counter value k that starts 2 cycles after sp. Pulse start, wait for done, read addr 0..1023 -> rd_i==k at addr k, done rises after 1024 CAPT cycles, busy was high 1025 cycles.
- delay=5, fb_i = cycle count since reset: the value captured at addr 0 equals the sp cycle + 7. addr 1023 holds that value + 1023.
- Restart mid-capture: second start edge at wr_addr=300 -> busy stays high, done stays 0, final frame begins at the new alignment, and every addr 0..1023 holds second-capture data.
- Async reset_b low at wr_addr=500 -> busy=0, done=0, rd_valid=0 immediately. A new start afterwards completes normally.
- Read during CAPT at the address being written -> returns the previous frame's value. rd_valid follows rd_en with exactly 1 cycle latency, including back-to-back reads.
- start held high for 2000 cycles -> exactly one capture. done stays 1 with no retrigger until start falls and rises again.

Source files
------------

// File: rtl/dpd_pkg.sv
// Shared types and constants for the DPD feedback-capture path.
package dpd_pkg;

  typedef logic       u1;
  typedef logic [9:0] u10;

  // Capture controller states.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPT,
    DONE
  } cap_state_t;

  // Number of I/Q samples in one captured training frame.
  localparam int DPD_FRAME_LEN = 1024;

endpackage

// File: rtl/dpd_iq_ram.sv
// Simple dual-port I/Q sample buffer: one write port, one registered read port.
// A read and a write to the same address in the same cycle returns the old word.
module dpd_iq_ram
  import dpd_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            reset_b,
  input  u1               we,
  input  logic [AW-1:0]   waddr,
  input  logic [2*W-1:0]  wdata,
  input  u1               re,
  input  logic [AW-1:0]   raddr,
  output logic [2*W-1:0]  rdata
);

  logic [2*W-1:0] mem [2**AW];
  logic [2*W-1:0] rdata_q;
  logic [2*W-1:0] rdata_d;

  // Write port: store one packed {I, Q} word per enabled cycle.
  // NOTE: the array has no reset; a reset loop over every word would stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data: load a new word on re, otherwise hold the previous one.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Read output register; cleared by reset so the port starts at zero.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dpd_capture.sv
// Feedback-path capture buffer for DPD training. A rising edge on start arms
// a programmable alignment delay, after which exactly one frame of I/Q
// feedback samples is written into the buffer; the estimator reads it back
// through a random-access port with one cycle of latency.
module dpd_capture
  import dpd_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          start,
  input  logic [DW-1:0] delay,
  input  logic [W-1:0]  fb_i,
  input  logic [W-1:0]  fb_q,
  output logic          busy,
  output logic          done,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_i,
  output logic [W-1:0]  rd_q,
  output logic          rd_valid
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  // Start edge detector. Left unreset so its latency matches the
  // training-signal player exactly.
  u1 s0_q, s0_d;
  u1 s1_q, s1_d;
  u1 sp_q, sp_d;

  // Controller state.
  cap_state_t    state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  u1             rd_valid_q, rd_valid_d;
  u1             wr_en;

  logic [2*W-1:0] rd_data;

  // Edge detect: sp is a registered one-cycle pulse on a 0->1 start transition.
  always_comb begin
    s0_d = start;
    s1_d = s0_q;
    sp_d = s0_q & ~s1_q;
  end

  // Start synchroniser and pulse flops.
  // NOTE: sequential state always uses <=, so every flop sees pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    s0_q <= s0_d;
    s1_q <= s1_d;
    sp_q <= sp_d;
  end

  // Next-state logic: a start pulse restarts from any state, otherwise
  // count down the alignment delay and then fill the frame once.
  // NOTE: every signal gets its default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    wr_addr_d = wr_addr_q;
    wr_en     = 1'b0;

    if (sp_q) begin
      dly_d     = delay;
      wr_addr_d = '0;
      state_d   = WAIT;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        WAIT: begin
          if (dly_q == '0) begin
            state_d = CAPT;
          end else begin
            dly_d = dly_q - DW'(1);
          end
        end
        CAPT: begin
          wr_en = 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            wr_addr_d = wr_addr_q + AW'(1);
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Read-valid simply tracks the request one cycle later.
  always_comb begin
    rd_valid_d = rd_en;
  end

  // Controller and read-valid registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      dly_q      <= '0;
      wr_addr_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      wr_addr_q  <= wr_addr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  dpd_iq_ram #(
    .W  (W),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .reset_b (reset_b),
    .we      (wr_en),
    .waddr   (wr_addr_q),
    .wdata   ({fb_i, fb_q}),
    .re      (rd_en),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

  assign busy     = (state_q == WAIT) || (state_q == CAPT);
  assign done     = (state_q == DONE);
  assign rd_i     = rd_data[2*W-1:W];
  assign rd_q     = rd_data[W-1:0];
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_dpd_capture.sv
// Bench for dpd_capture: a timing/frame model derived from the start edge,
// the latched delay and the frame length, checked every cycle, plus
// hand-computed expectations for latencies, lengths and captured values.
module tb_dpd_capture;
  import dpd_pkg::*;

  localparam int W  = 16;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam logic [15:0] QMASK = 16'h5A3C;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] delay = '0;
  logic [W-1:0]  fb_i = '0;
  logic [W-1:0]  fb_q = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          busy, done, rd_valid;
  logic [W-1:0]  rd_i, rd_q;

  dpd_capture #(.W(W), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .start    (start),
    .delay    (delay),
    .fb_i     (fb_i),
    .fb_q     (fb_q),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_i     (rd_i),
    .rd_q     (rd_q),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  pend_e  = -1;
  int  e_edge  = 0;
  int  m_d     = 0;
  bit  active  = 1'b0;
  bit  start_prev = 1'b0;
  logic [2*W-1:0] exp_mem [DPD_FRAME_LEN];
  bit  exp_ok [DPD_FRAME_LEN];
  bit  rdv_exp = 1'b0;
  logic [2*W-1:0] rd_exp = '0;
  bit  rd_known = 1'b1;

  always @(posedge clk or negedge reset_b) begin
    int cs;
    if (!reset_b) begin
      active   = 1'b0;
      rdv_exp  = 1'b0;
      rd_exp   = '0;
      rd_known = 1'b1;
    end else begin
      cyc++;
      rdv_exp = rd_en;
      if (rd_en) begin
        rd_exp   = exp_mem[rd_addr];
        rd_known = exp_ok[rd_addr];
      end
      if (cyc == pend_e) begin
        e_edge = cyc;
        m_d    = int'(delay);
        active = 1'b1;
      end else if (active) begin
        cs = e_edge + 2 + m_d;
        if (cyc >= cs && cyc < cs + DPD_FRAME_LEN) begin
          exp_mem[cyc - cs] = {fb_i, fb_q};
          exp_ok[cyc - cs]  = 1'b1;
        end
      end
      if (start && !start_prev) pend_e = cyc + 2;
      start_prev = start;
    end
  end

  // Feedback source: I is the index of the edge that will sample it.
  always @(negedge clk) begin
    fb_i = 16'(cyc + 1);
    fb_q = 16'(cyc + 1) ^ QMASK;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit eb, ed;
    if (chk_en && reset_b) begin
      eb = active && (cyc <= e_edge + m_d + DPD_FRAME_LEN);
      ed = active && !eb;
      check("busy", 32'(busy), 32'(eb));
      check("done", 32'(done), 32'(ed));
      check("rd_valid", 32'(rd_valid), 32'(rdv_exp));
      if (rd_known) check("rd_iq", {rd_i, rd_q}, rd_exp);
    end
  end

  int busy_tot = 0;
  always @(negedge clk) if (reset_b && busy) busy_tot++;

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input int d, output int e);
    @(negedge clk);
    delay = DW'(d);
    start = 1'b1;
    e = cyc + 3;
    repeat (3) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    dc = cyc;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("wait_cyc", 32'(cyc), 32'(target));
  endtask

  task automatic single_read(input int a, output logic [W-1:0] vi, output logic [W-1:0] vq);
    @(negedge clk);
    rd_en = 1'b1;
    rd_addr = AW'(a);
    @(negedge clk);
    vi = rd_i;
    vq = rd_q;
    rd_en = 1'b0;
  endtask

  task automatic read_frame(input int base);
    for (int a = 0; a <= DPD_FRAME_LEN; a++) begin
      @(negedge clk);
      if (a > 0) check("frame_i", 32'(rd_i), 32'(16'(base + a - 1)));
      if (a < DPD_FRAME_LEN) begin
        rd_en = 1'b1;
        rd_addr = AW'(a);
      end else begin
        rd_en = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int e1, e2, e3, e4, e5, e6, e7, e8, dc, b0;
    logic [W-1:0] vi, vq;

    repeat (4) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_i", 32'(rd_i), 32'd0);
    check("rst_rd_q", 32'(rd_q), 32'd0);
    #2 reset_b = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // Zero-delay loopback: address k holds the sample from edge E+2+k.
    b0 = busy_tot;
    pulse(0, e1);
    wait_done(1200, dc);
    check("t1_done_latency", 32'(dc - e1), 32'd1025);
    check("t1_busy_len", 32'(busy_tot - b0), 32'd1025);
    single_read(0, vi, vq);
    check("t1_addr0_i", 32'(vi), 32'(16'(e1 + 2)));
    check("t1_addr0_q", 32'(vq), 32'(16'(e1 + 2) ^ QMASK));
    single_read(1023, vi, vq);
    check("t1_addr1023_i", 32'(vi), 32'(16'(e1 + 2 + 1023)));
    read_frame(e1 + 2);

    // delay=5, plus back-to-back reads of the address being written.
    b0 = busy_tot;
    pulse(5, e2);
    wait_cyc(e2 + 7 + 99);
    rd_en = 1'b1;
    rd_addr = AW'(100);
    @(negedge clk);
    check("rbw_valid0", 32'(rd_valid), 32'd1);
    check("rbw_old0", 32'(rd_i), 32'(16'(e1 + 2 + 100)));
    rd_addr = AW'(101);
    @(negedge clk);
    check("rbw_valid1", 32'(rd_valid), 32'd1);
    check("rbw_old1", 32'(rd_i), 32'(16'(e1 + 2 + 101)));
    rd_en = 1'b0;
    @(negedge clk);
    check("rbw_valid_drop", 32'(rd_valid), 32'd0);
    check("rbw_hold", 32'(rd_i), 32'(16'(e1 + 2 + 101)));
    wait_done(1200, dc);
    check("t2_done_latency", 32'(dc - e2), 32'd1030);
    check("t2_busy_len", 32'(busy_tot - b0), 32'd1030);
    single_read(0, vi, vq);
    check("t2_addr0", 32'(vi), 32'(16'(e2 + 7)));
    single_read(1023, vi, vq);
    check("t2_addr1023", 32'(vi), 32'(16'(e2 + 7 + 1023)));

    // Restart at wr_addr=300; later delay changes must not matter.
    pulse(3, e3);
    wait_cyc(e3 + 5 + 299);
    pulse(2, e4);
    delay = DW'(50);
    check("t3_busy_kept", 32'(busy), 32'd1);
    wait_done(1200, dc);
    check("t3_done_latency", 32'(dc - e4), 32'd1027);
    read_frame(e4 + 4);

    // Asynchronous reset in the middle of a capture.
    pulse(0, e5);
    wait_cyc(e5 + 2 + 499);
    rd_en = 1'b1;
    rd_addr = AW'(7);
    @(posedge clk);
    #2 reset_b = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_rd_valid", 32'(rd_valid), 32'd0);
    check("arst_rd_i", 32'(rd_i), 32'd0);
    rd_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset_b = 1'b1;
    single_read(200, vi, vq);
    check("arst_partial_new", 32'(vi), 32'(16'(e5 + 2 + 200)));
    single_read(600, vi, vq);
    check("arst_partial_old", 32'(vi), 32'(16'(e4 + 4 + 600)));
    pulse(1, e6);
    wait_done(1200, dc);
    check("t4_done_latency", 32'(dc - e6), 32'd1026);
    read_frame(e6 + 3);

    // start held high for 2000 cycles gives exactly one capture.
    b0 = busy_tot;
    @(negedge clk);
    delay = DW'(0);
    start = 1'b1;
    e7 = cyc + 3;
    repeat (2000) @(negedge clk);
    check("t5_done_held", 32'(done), 32'd1);
    check("t5_single_capture", 32'(busy_tot - b0), 32'd1025);
    single_read(0, vi, vq);
    check("t5_addr0", 32'(vi), 32'(16'(e7 + 2)));
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_done_after_fall", 32'(done), 32'd1);
    pulse(0, e8);
    check("t5_retrigger", 32'(done), 32'd0);
    wait_done(1200, dc);
    single_read(5, vi, vq);
    check("t5_new_addr5", 32'(vi), 32'(16'(e8 + 7)));

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
